// File: rtl/h_pixel_timer_if.sv
// Horizontal pixel timer bus: run enable in, pixel timing and sync decode out.
interface h_pixel_timer_if;
    logic       en;
    logic       pixel_tick;
    logic [9:0] h_count;
    logic       enable_v;
    logic       hsync;
    logic       h_video_on;

    modport master (
        input  en,
        output pixel_tick,
        output h_count,
        output enable_v,
        output hsync,
        output h_video_on
    );

    modport slave (
        output en,
        input  pixel_tick,
        input  h_count,
        input  enable_v,
        input  hsync,
        input  h_video_on
    );
endinterface

// File: rtl/h_pixel_timer.sv
// Horizontal pixel timer: divides clk into pixel steps, counts pixels per line and
// decodes hsync / visible region with all outputs registered.
module h_pixel_timer #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48
) (
    input  logic            clk,
    input  logic            reset,
    h_pixel_timer_if.master tmr
);
    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    // Keep the divider at least one bit wide so CLK_DIV=1 still elaborates.
    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivMax    = DivW'(CLK_DIV - 1);
    localparam logic [9:0]      HMax      = 10'(HTotal - 1);
    localparam logic [9:0]      HActEnd   = 10'(H_ACTIVE);
    localparam logic [9:0]      SyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]      SyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]      h_count_q, h_count_d;
    logic            pixel_tick_q, pixel_tick_d;
    logic            enable_v_q, enable_v_d;
    logic            hsync_q, hsync_d;
    logic            h_video_on_q, h_video_on_d;
    logic            step;

    always_comb begin
        step         = tmr.en && (div_cnt_q == DivMax);
        div_cnt_d    = div_cnt_q;
        h_count_d    = h_count_q;
        pixel_tick_d = 1'b0;
        enable_v_d   = 1'b0;
        if (step) begin
            div_cnt_d    = '0;
            h_count_d    = (h_count_q == HMax) ? 10'd0 : h_count_q + 10'd1;
            pixel_tick_d = 1'b1;
            enable_v_d   = (h_count_q == HMax);
        end else if (tmr.en) begin
            div_cnt_d = div_cnt_q + DivW'(1);
        end
        // Decode from the next count so sync and video track h_count with no lag.
        hsync_d      = !((h_count_d >= SyncStart) && (h_count_d < SyncEnd));
        h_video_on_d = (h_count_d < HActEnd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            h_count_q    <= '0;
            pixel_tick_q <= 1'b0;
            enable_v_q   <= 1'b0;
            hsync_q      <= 1'b1;
            h_video_on_q <= 1'b1;
        end else begin
            div_cnt_q    <= div_cnt_d;
            h_count_q    <= h_count_d;
            pixel_tick_q <= pixel_tick_d;
            enable_v_q   <= enable_v_d;
            hsync_q      <= hsync_d;
            h_video_on_q <= h_video_on_d;
        end
    end

    assign tmr.pixel_tick = pixel_tick_q;
    assign tmr.h_count    = h_count_q;
    assign tmr.enable_v   = enable_v_q;
    assign tmr.hsync      = hsync_q;
    assign tmr.h_video_on = h_video_on_q;
endmodule

// File: tb/tb_h_pixel_timer.sv
// Bench for h_pixel_timer: default timing and a CLK_DIV=1 variant, checked each cycle
// against an arithmetic model of enabled clocks since reset.
module tb_h_pixel_timer;
    typedef struct packed {
        logic [9:0] h;
        logic       tick;
        logic       ev;
        logic       hs;
        logic       vid;
    } obs_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int unsigned n_en;
    obs_t q0[$];
    obs_t q1[$];

    h_pixel_timer_if bus0 ();
    h_pixel_timer_if bus1 ();

    h_pixel_timer u_dut0 (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus0)
    );

    h_pixel_timer #(
        .CLK_DIV (1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .tmr   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected state after n enabled clocks since reset; stepped says this edge made a pixel.
    function automatic obs_t ref_obs(int unsigned n, bit stepped, int unsigned div);
        obs_t o;
        int unsigned h;
        h      = (n / div) % 800;
        o.h    = 10'(h);
        o.tick = stepped;
        o.ev   = stepped && (h == 0);
        o.hs   = !(h >= 656 && h < 752);
        o.vid  = (h < 640);
        return o;
    endfunction

    function automatic obs_t obs_of0();
        return {bus0.h_count, bus0.pixel_tick, bus0.enable_v, bus0.hsync, bus0.h_video_on};
    endfunction

    function automatic obs_t obs_of1();
        return {bus1.h_count, bus1.pixel_tick, bus1.enable_v, bus1.hsync, bus1.h_video_on};
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got h_count=%0d tick=%0b enable_v=%0b hsync=%0b video=%0b, want h_count=%0d tick=%0b enable_v=%0b hsync=%0b video=%0b",
                     name, $time, act.h, act.tick, act.ev, act.hs, act.vid,
                     exp.h, exp.tick, exp.ev, exp.hs, exp.vid);
        end
    endtask

    // Monitor: every sampled cycle, pop the expected output and compare.
    always @(negedge clk) begin
        if (q0.size() > 0) chk("div4", obs_of0(), q0.pop_front());
        if (q1.size() > 0) chk("div1", obs_of1(), q1.pop_front());
    end

    // Called between negedge and posedge; returns at the same phase one cycle later.
    task automatic cycle(input bit e);
        bit en_now;
        bus0.en = e;
        bus1.en = e;
        en_now  = e;
        @(posedge clk);
        if (en_now) n_en++;
        q0.push_back(ref_obs(n_en, en_now && (n_en % 4 == 0), 4));
        q1.push_back(ref_obs(n_en, en_now, 1));
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input string name);
        obs_t rst_val;
        rst_val = {10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        reset   = 1'b1;
        bus0.en = 1'b1;
        bus1.en = 1'b1;
        #1;
        chk({name, "_async0"}, obs_of0(), rst_val);
        chk({name, "_async1"}, obs_of1(), rst_val);
        n_en = 0;
        repeat (3) begin
            @(posedge clk);
            q0.push_back(rst_val);
            q1.push_back(rst_val);
            @(negedge clk);
            #2;
        end
        reset = 1'b0;
    endtask

    initial begin
        int unsigned guard;
        errors  = 0;
        checks  = 0;
        n_en    = 0;
        reset   = 1'b0;
        bus0.en = 1'b0;
        bus1.en = 1'b0;
        #2;
        do_reset("por");

        // Clean start then a long randomized run with occasional en drops.
        repeat (40) cycle(1'b1);
        repeat (4000) cycle(($urandom % 8) != 0);

        // Reach h_count=799 with div_cnt=3, then reset between edges before the wrap.
        guard = 0;
        while ((n_en % 3200) != 3199 && guard < 4000) begin
            cycle(1'b1);
            guard++;
        end
        checks++;
        if (guard >= 4000) begin
            errors++;
            $display("FAIL reach_799: got guard=%0d, want < 4000", guard);
        end
        do_reset("wrap_abort");

        repeat (1500) cycle(($urandom % 8) != 0);

        // Abort a line while hsync is low.
        guard = 0;
        while (!(((n_en / 4) % 800) >= 660 && ((n_en / 4) % 800) < 740) && guard < 4000) begin
            cycle(($urandom % 4) != 0);
            guard++;
        end
        checks++;
        if (guard >= 4000) begin
            errors++;
            $display("FAIL reach_sync: got guard=%0d, want < 4000", guard);
        end
        do_reset("sync_abort");

        repeat (1000) cycle(($urandom % 8) != 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
